// File: rtl/mips_hazard_pkg.sv
// Shared types and defaults for the ID-stage hazard controller and its mult/div busy timer.
package mips_hazard_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } md_state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    localparam int unsigned MULT_LAT_DEF = 4;
    localparam int unsigned DIV_LAT_DEF  = 12;

endpackage

// File: rtl/md_busy_timer.sv
// Mult/div HI/LO occupancy timer: IDLE/BUSY FSM with a down-counter loaded on accept.
module md_busy_timer
    import mips_hazard_pkg::*;
#(
    parameter int unsigned MULT_LAT = MULT_LAT_DEF,
    parameter int unsigned DIV_LAT  = DIV_LAT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic accept,
    input  logic isDiv,
    output logic mdBusy,
    output logic mdDone
);

    localparam int unsigned CntW = (DIV_LAT > 1) ? $clog2(DIV_LAT) : 1;
    localparam logic [CntW-1:0] MultLoad = CntW'(MULT_LAT - 1);
    localparam logic [CntW-1:0] DivLoad  = CntW'(DIV_LAT - 1);

    md_state_t       state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Counter holds the number of busy cycles left after the current one.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = BUSY;
                    cnt_d   = isDiv ? DivLoad : MultLoad;
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign mdBusy = (state_q == BUSY);
    assign mdDone = (state_q == BUSY) && (cnt_q == '0);

endmodule

// File: rtl/hazard_stall_unit.sv
// ID-stage hazard controller: load-use, HI/LO occupancy and taken-branch squash.
// Optional stall/flush performance counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_stall_unit
    import mips_hazard_pkg::*;
#(
    parameter int unsigned MULT_LAT = MULT_LAT_DEF,
    parameter int unsigned DIV_LAT  = DIV_LAT_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  idRs,
    input  logic [4:0]  idRt,
    input  logic        idUsesRs,
    input  logic        idUsesRt,
    input  logic        exMemRead,
    input  logic        exRegWrite,
    input  logic [4:0]  exRt,
    input  logic        mdStart,
    input  logic        mdIsDiv,
    input  logic        idReadsHiLo,
    input  logic        branchTaken,
    output logic        stallF,
    output logic        stallD,
    output logic        flushD,
    output logic        flushE,
    output logic        mdBusy,
    output logic        mdDone
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] stallCount,
    output logic [31:0] flushCount
`endif
);

    logic lu_haz, md_haz, accept;

    always_comb begin
        lu_haz = exMemRead & exRegWrite & (exRt != REG_ZERO) &
                 ((idUsesRs & (exRt == idRs)) | (idUsesRt & (exRt == idRt)));
        md_haz = mdBusy & (idReadsHiLo | mdStart);
        accept = mdStart & ~branchTaken & ~lu_haz & ~md_haz;

        stallF = 1'b0;
        stallD = 1'b0;
        flushD = 1'b0;
        flushE = 1'b0;
        // Outputs are forced quiet while reset is held, even with live inputs.
        if (rst_n) begin
            if (branchTaken) begin
                flushD = 1'b1;
                flushE = 1'b1;
            end else if (lu_haz || md_haz) begin
                stallF = 1'b1;
                stallD = 1'b1;
                flushE = 1'b1;
            end
        end
    end

    md_busy_timer #(
        .MULT_LAT (MULT_LAT),
        .DIV_LAT  (DIV_LAT)
    ) u_md_busy_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .accept (accept),
        .isDiv  (mdIsDiv),
        .mdBusy (mdBusy),
        .mdDone (mdDone)
    );

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stallD && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
        if (flushD && (flush_cnt_q != 32'hFFFF_FFFF)) flush_cnt_d = flush_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stallCount = stall_cnt_q;
    assign flushCount = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Self-checking bench for hazard_stall_unit: vector table, hand sequences and random stimulus
// against a remaining-busy-cycles reference model.
module tb_hazard_stall_unit;

    localparam int unsigned MULT_LAT = 4;
    localparam int unsigned DIV_LAT  = 12;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] idRs, idRt, exRt;
    logic       idUsesRs, idUsesRt, exMemRead, exRegWrite;
    logic       mdStart, mdIsDiv, idReadsHiLo, branchTaken;
    logic       stallF, stallD, flushD, flushE, mdBusy, mdDone;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stallCount, flushCount;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_stall_unit #(
        .MULT_LAT (MULT_LAT),
        .DIV_LAT  (DIV_LAT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .idRs        (idRs),
        .idRt        (idRt),
        .idUsesRs    (idUsesRs),
        .idUsesRt    (idUsesRt),
        .exMemRead   (exMemRead),
        .exRegWrite  (exRegWrite),
        .exRt        (exRt),
        .mdStart     (mdStart),
        .mdIsDiv     (mdIsDiv),
        .idReadsHiLo (idReadsHiLo),
        .branchTaken (branchTaken),
        .stallF      (stallF),
        .stallD      (stallD),
        .flushD      (flushD),
        .flushE      (flushE),
        .mdBusy      (mdBusy),
        .mdDone      (mdDone)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stallCount  (stallCount),
        .flushCount  (flushCount)
`endif
    );

    // Reference model: HI/LO occupancy as a count of busy cycles still to come.
    int unsigned rem;
    logic        m_lu, m_md, m_accept;
    logic [5:0]  m_exp;  // {stallF, stallD, flushD, flushE, mdBusy, mdDone}

    always_comb begin
        m_lu = exMemRead && exRegWrite && exRt != 0 &&
               ((idUsesRs && exRt == idRs) || (idUsesRt && exRt == idRt));
        m_md = (rem != 0) && (idReadsHiLo || mdStart);
        m_accept = mdStart && !branchTaken && !m_lu && !m_md;
        m_exp = '0;
        m_exp[1] = (rem != 0);
        m_exp[0] = (rem == 1);
        if (rst_n) begin
            if (branchTaken) m_exp[5:2] = 4'b0011;
            else if (m_lu || m_md) m_exp[5:2] = 4'b1101;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) rem <= 0;
        else if (rem != 0) rem <= rem - 1;
        else if (m_accept) rem <= mdIsDiv ? DIV_LAT : MULT_LAT;
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] m_sc, m_fc;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_sc <= '0;
            m_fc <= '0;
        end else begin
            if (m_exp[4] && m_sc != 32'hFFFF_FFFF) m_sc <= m_sc + 1;
            if (m_exp[3] && m_fc != 32'hFFFF_FFFF) m_fc <= m_fc + 1;
        end
    end
`endif

    typedef struct {
        logic [4:0] rs, rt;
        logic       urs, urt, mrd, rwr;
        logic [4:0] ert;
        logic       mds, div, hilo, br;
        logic [3:0] exp;  // {stallF, stallD, flushD, flushE}
    } vec_t;

    vec_t tbl[12];

    function automatic vec_t mk(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                                input logic urt, input logic mrd, input logic rwr,
                                input logic [4:0] ert, input logic mds, input logic div,
                                input logic hilo, input logic br, input logic [3:0] exp);
        vec_t v;
        v.rs = rs; v.rt = rt; v.urs = urs; v.urt = urt; v.mrd = mrd; v.rwr = rwr;
        v.ert = ert; v.mds = mds; v.div = div; v.hilo = hilo; v.br = br; v.exp = exp;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        idRs = v.rs; idRt = v.rt; idUsesRs = v.urs; idUsesRt = v.urt;
        exMemRead = v.mrd; exRegWrite = v.rwr; exRt = v.ert;
        mdStart = v.mds; mdIsDiv = v.div; idReadsHiLo = v.hilo; branchTaken = v.br;
    endtask

    task automatic idle_in();
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000));
    endtask

    task automatic check(input string nm, input logic [5:0] got, input logic [5:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got {sF,sD,fD,fE,busy,done}=%b want %b at %0t", nm, got, exp,
                     $time);
        end
    endtask

    function automatic logic [5:0] dut_out();
        return {stallF, stallD, flushD, flushE, mdBusy, mdDone};
    endfunction

    // Check DUT against model at negedge (and optionally against an explicit value),
    // then advance past the next rising edge.
    task automatic step(input string nm, input bit use_exp, input logic [5:0] exp);
        @(negedge clk);
        check({nm, "/model"}, dut_out(), m_exp);
        if (use_exp) check(nm, dut_out(), exp);
`ifdef HAZARD_PERF_CNT_EN
        checks++;
        if (stallCount !== m_sc || flushCount !== m_fc) begin
            errors++;
            $display("FAIL %s/perf: got stall=%0d flush=%0d want stall=%0d flush=%0d", nm,
                     stallCount, flushCount, m_sc, m_fc);
        end
`endif
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t v;
        tbl[0]  = mk(5, 0, 1, 0, 1, 1, 5, 0, 0, 0, 0, 4'b1101);  // load-use on rs
        tbl[1]  = mk(5, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000);  // EX bubble
        tbl[2]  = mk(0, 0, 1, 1, 1, 1, 0, 0, 0, 0, 0, 4'b0000);  // $zero never hazards
        tbl[3]  = mk(0, 7, 0, 0, 1, 1, 7, 0, 0, 0, 0, 4'b0000);  // rt match but unused
        tbl[4]  = mk(3, 7, 1, 1, 1, 1, 7, 0, 0, 0, 0, 4'b1101);  // load-use on rt
        tbl[5]  = mk(5, 0, 1, 0, 1, 0, 5, 0, 0, 0, 0, 4'b0000);  // no regwrite
        tbl[6]  = mk(6, 0, 1, 0, 1, 1, 5, 0, 0, 0, 0, 4'b0000);  // register mismatch
        tbl[7]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4'b0011);  // branch alone
        tbl[8]  = mk(5, 0, 1, 0, 1, 1, 5, 1, 0, 0, 1, 4'b0011);  // branch beats lu + md
        tbl[9]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 4'b0000);  // MFLO while idle
        tbl[10] = mk(5, 0, 1, 0, 1, 1, 5, 1, 1, 0, 0, 4'b1101);  // DIV stalled by load-use
        tbl[11] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000);  // nothing started

        idle_in();
        #2;
        check("reset_outputs", dut_out(), 6'b000000);
        apply(tbl[0]);
        #1;
        check("reset_gates_luhaz", dut_out(), 6'b000000);
        idle_in();
        #13;
        rst_n = 1'b1;  // t=16: between a rising edge and the following falling edge

        for (int i = 0; i < 12; i++) begin
            apply(tbl[i]);
            step($sformatf("vec%0d", i), 1'b1, {tbl[i].exp, 2'b00});
        end

        // MULT accepted, then MFLO waits out the busy window.
        v = tbl[11]; v.mds = 1; v.div = 0;
        apply(v);
        step("mult_issue", 1'b1, 6'b000000);
        for (int i = 1; i <= 5; i++) begin
            v = tbl[11]; v.hilo = 1;
            apply(v);
            step($sformatf("mflo_c%0d", i), 1'b1,
                 (i <= 4) ? {4'b1101, 1'b1, i == 4} : 6'b000000);
        end

        // DIV, then a MULT held against it; branch mid-way must not cancel the timer.
        v = tbl[11]; v.mds = 1; v.div = 1;
        apply(v);
        step("div_issue", 1'b1, 6'b000000);
        for (int i = 1; i <= 18; i++) begin
            v = tbl[11];
            v.mds = (i <= 13);
            v.br = (i == 15);
            apply(v);
            if (i <= 12)      step($sformatf("div_c%0d", i), 1'b1, {4'b1101, 1'b1, i == 12});
            else if (i == 13) step("b2b_accept", 1'b1, 6'b000000);
            else if (i == 15) step("br_in_busy", 1'b1, 6'b001110);
            else if (i <= 17) step($sformatf("mult2_c%0d", i), 1'b1, {5'b00001, i == 17});
            else              step("b2b_done", 1'b1, 6'b000000);
        end

        // Reset asserted during DIV busy cycle 6.
        v = tbl[11]; v.mds = 1; v.div = 1;
        apply(v);
        step("div2_issue", 1'b1, 6'b000000);
        for (int i = 1; i <= 5; i++) begin
            v = tbl[11]; v.hilo = 1;
            apply(v);
            step($sformatf("div2_c%0d", i), 1'b1, 6'b110110);
        end
        v = tbl[11]; v.hilo = 1;
        apply(v);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_mid_busy", dut_out(), 6'b000000);
`ifdef HAZARD_PERF_CNT_EN
        checks++;
        if (stallCount !== 32'd0 || flushCount !== 32'd0) begin
            errors++;
            $display("FAIL rst_perf: got stall=%0d flush=%0d want 0 0", stallCount, flushCount);
        end
`endif
        #1;
        rst_n = 1'b1;
        step("after_rst", 1'b1, 6'b000000);

        for (int i = 0; i < 3000; i++) begin
            idRs        = 5'($urandom_range(0, 3));
            idRt        = 5'($urandom_range(0, 3));
            exRt        = 5'($urandom_range(0, 3));
            idUsesRs    = 1'($urandom_range(0, 1));
            idUsesRt    = 1'($urandom_range(0, 1));
            exMemRead   = ($urandom_range(0, 2) == 0);
            exRegWrite  = ($urandom_range(0, 3) != 0);
            mdStart     = ($urandom_range(0, 5) == 0);
            mdIsDiv     = 1'($urandom_range(0, 1));
            idReadsHiLo = ($urandom_range(0, 3) == 0);
            branchTaken = ($urandom_range(0, 7) == 0);
            step("rand", 1'b0, 6'b000000);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- Pipeline hazard controller in ID. Generates stall/flush for the IF/ID and ID/EX registers; ID/EX in turn supplies exRs/exRt to the forwarding unit.
- Covers the hazards forwarding cannot resolve:
  - load-use;
  - multicycle MULT/DIV occupancy of HI/LO;
  - taken-branch squash.
- Contains a busy-timer FSM for the mult/div unit.

Parameters:
MULT_LAT, 4, cycles HI/LO is busy after an accepted MULT (>=1)
DIV_LAT, 12, cycles HI/LO is busy after an accepted DIV (>=1, >=MULT_LAT)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
idRs  input  5  rs field of instruction in ID
idRt  input  5  rt field of instruction in ID
idUsesRs  input  1  ID instruction reads rs
idUsesRt  input  1  ID instruction reads rt
exMemRead  input  1  instruction in EX is a load
exRegWrite  input  1  instruction in EX writes a register
exRt  input  5  destination (rt) of load in EX
mdStart  input  1  ID instruction is MULT/DIV
mdIsDiv  input  1  qualifies mdStart: 1=DIV, 0=MULT
idReadsHiLo  input  1  ID instruction is MFHI/MFLO
branchTaken  input  1  branch resolved taken in EX this cycle
stallF  output  1  hold PC
stallD  output  1  hold IF/ID
flushD  output  1  clear IF/ID
flushE  output  1  insert bubble into ID/EX
mdBusy  output  1  HI/LO result pending
mdDone  output  1  one-cycle pulse, last busy cycle

Behaviour:
- Reset (async on rst_n low): FSM=IDLE, counter=0, all outputs 0. A reset asserted mid-operation abandons any busy period; after release, mdBusy=0.
- Outputs are combinational from inputs and registered state; zero-cycle latency.
- luHaz = exMemRead & exRegWrite & (exRt!=0) & ((idUsesRs & exRt==idRs) | (idUsesRt & exRt==idRt)).
- mdHaz = mdBusy & (idReadsHiLo | mdStart).
- Priority, highest first:
  - branchTaken: flushD=1, flushE=1, stallF=stallD=0. Overrides luHaz/mdHaz.
  - luHaz or mdHaz: stallF=stallD=1, flushE=1, flushD=0.
  - else: all 0.
- Accept: mdStart & !branchTaken & !luHaz & !mdHaz, sampled at a rising edge. An mdStart that is stalled retries in a later cycle; one that is flushed never starts.
- FSM states: IDLE, BUSY.
  - IDLE -> BUSY on accept. Counter loads DIV_LAT-1 if mdIsDiv, else MULT_LAT-1.
  - BUSY: counter decrements each cycle. When counter==0, go to IDLE.
  - mdBusy=1 exactly in state BUSY. For acceptance at edge k, busy spans cycles k+1..k+LAT.
  - mdDone=1 in BUSY when counter==0.
- No new accept is possible while BUSY, because mdHaz stalls it. A MULT/DIV issued in the last busy cycle is accepted at the following edge, giving back-to-back busy periods with one IDLE cycle between them.
- A branch flush does not cancel an in-flight mult/div. Its timer continues.
- Counter width: $clog2(DIV_LAT); wrap-around impossible by construction.

Optional Feature:
Macro HAZARD_PERF_CNT_EN.
- Defined: adds two outputs, stallCount[31:0] and flushCount[31:0].
  - stallCount increments on every cycle with stallD=1.
  - flushCount increments on every cycle with flushD=1.
  - Both reset to 0 and saturate at 32'hFFFF_FFFF.
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package mips_hazard_pkg:
  - md_state_t enum {IDLE, BUSY};
  - REG_ZERO=5'd0;
  - default MULT_LAT/DIV_LAT constants.
- Sub-module md_busy_timer: the FSM plus down-counter.
  - Inputs: accept, isDiv.
  - Outputs: mdBusy, mdDone.
- Hazard combinational logic and priority stay in the top.

Test Plan:
- Load-use: exMemRead=1, exRegWrite=1, exRt=5, idRs=5, idUsesRs=1 -> stallF=stallD=flushE=1 that cycle. The next cycle, with EX a bubble, all 0.
- Zero-register and no-use:
  - exRt=0 with idRs=0 -> no stall.
  - exRt=7, idRt=7, idUsesRt=0 -> no stall.
- MULT then MFLO: accept MULT at edge k -> mdBusy=1 for cycles k+1..k+4 and mdDone=1 at k+4. idReadsHiLo held from k+1 -> stalls for 4 cycles, released at k+5.
- DIV timing and back-to-back: DIV accepted -> mdBusy lasts 12 cycles. A second MULT presented during BUSY is stalled until the IDLE cycle, then accepted -> 4 further busy cycles.
- Branch priority: branchTaken=1 together with luHaz=1 and mdStart=1 -> flushD=flushE=1, stallF=stallD=0, and no mult/div is started (mdBusy stays 0).
- Reset mid-busy: rst_n low during DIV cycle 6 -> outputs 0 immediately and mdBusy=0 after release. With HAZARD_PERF_CNT_EN defined, the counters read 0 after reset and increment per stall/flush cycle.
